// File: rtl/vending_session_arbiter_if.sv
// Slot-side and machine-side signals of the vending session arbiter.
// master = arbiter, slave = slot front-ends plus the VendingMachine.
interface vending_session_arbiter_if #(
  parameter int N_SLOTS = 4
);
  localparam int W = $clog2(N_SLOTS);

  logic [2*N_SLOTS-1:0] slot_coin;
  logic [N_SLOTS-1:0]   slot_coin_ready;
  logic [N_SLOTS-1:0]   slot_valid;
  logic [1:0]           vm_coin;
  logic                 vm_valid;
  logic                 vm_clear;
  logic [W-1:0]         owner;
  logic                 busy;
  logic                 err;

  modport master (
    input  slot_coin, vm_valid,
    output slot_coin_ready, slot_valid, vm_coin,
    output vm_clear, owner, busy, err
  );

  modport slave (
    output slot_coin, vm_valid,
    input  slot_coin_ready, slot_valid, vm_coin,
    input  vm_clear, owner, busy, err
  );
endinterface

// File: rtl/vending_session_arbiter.sv
// Shares one VendingMachine among N coin slots, one purchase session
// at a time, round-robin grant, idle timeout with credit clear.
module vending_session_arbiter #(
  parameter int N_SLOTS = 4,
  parameter int TIMEOUT = 15,
  parameter int CLR_LEN = 2
) (
  input logic clk,
  input logic reset,
  vending_session_arbiter_if.master bus
);
  localparam int W = $clog2(N_SLOTS);

  typedef enum logic [1:0] {
    IDLE, SESSION, VEND, ABORT
  } state_t;

  state_t state, state_n;

  logic [W-1:0] owner, owner_n;
  logic [W-1:0] last, last_n;
  logic [W-1:0] pick, idx;
  logic         any;
  logic [7:0]   timer, timer_n;
  logic [2:0]   clr_cnt, clr_cnt_n;
  logic [1:0]   vm_coin, vm_coin_n;
  logic         vm_clear, vm_clear_n;
  logic         err, err_n;
  logic [N_SLOTS-1:0] slot_valid, slot_valid_n;
  logic [N_SLOTS-1:0] ready;
  logic [1:0]   coins [N_SLOTS];
  logic [1:0]   pick_coin, own_coin;

  // split the packed coin bus into per-slot values
  always_comb begin
    for (int i = 0; i < N_SLOTS; i++)
      coins[i] = bus.slot_coin[2*i +: 2];
  end

  // round-robin pick: first slot with a coin after last, wrapping
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int k = N_SLOTS; k >= 1; k--) begin
      idx = W'((int'(last) + k) % N_SLOTS);
      if (coins[idx] != 2'd0) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

  assign pick_coin = coins[pick];
  assign own_coin  = coins[owner];

  // next-state and registered-output decode
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_n       = last;
    timer_n      = timer;
    clr_cnt_n    = clr_cnt;
    vm_coin_n    = 2'd0;
    vm_clear_n   = 1'b0;
    err_n        = 1'b0;
    slot_valid_n = '0;
    ready        = '0;
    unique case (state)
      IDLE: begin
        if (any) begin
          ready[pick] = 1'b1;
          owner_n     = pick;
          timer_n     = 8'd0;
          state_n     = SESSION;
          if (pick_coin == 2'd3) err_n = 1'b1;
          else vm_coin_n = pick_coin;
        end
      end
      SESSION: begin
        if (bus.vm_valid) begin
          state_n             = VEND;
          slot_valid_n[owner] = 1'b1;
        end else if (own_coin != 2'd0) begin
          ready[owner] = 1'b1;
          timer_n      = 8'd0;
          if (own_coin == 2'd3) err_n = 1'b1;
          else vm_coin_n = own_coin;
        end else begin
          if (timer != 8'hFF) timer_n = timer + 8'd1;
          if (timer == 8'(TIMEOUT - 1)) begin
            state_n    = ABORT;
            clr_cnt_n  = 3'd0;
            vm_clear_n = 1'b1;
          end
        end
      end
      VEND: begin
        last_n  = owner;
        state_n = IDLE;
      end
      ABORT: begin
        if (clr_cnt == 3'(CLR_LEN - 1)) begin
          last_n  = owner;
          state_n = IDLE;
        end else begin
          clr_cnt_n  = clr_cnt + 3'd1;
          vm_clear_n = 1'b1;
        end
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= '0;
      last       <= W'(N_SLOTS - 1);
      timer      <= 8'd0;
      clr_cnt    <= 3'd0;
      vm_coin    <= 2'd0;
      vm_clear   <= 1'b0;
      err        <= 1'b0;
      slot_valid <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last       <= last_n;
      timer      <= timer_n;
      clr_cnt    <= clr_cnt_n;
      vm_coin    <= vm_coin_n;
      vm_clear   <= vm_clear_n;
      err        <= err_n;
      slot_valid <= slot_valid_n;
    end
  end

  assign bus.slot_coin_ready = ready;
  assign bus.slot_valid      = slot_valid;
  assign bus.vm_coin         = vm_coin;
  assign bus.vm_clear        = vm_clear;
  assign bus.owner           = owner;
  assign bus.busy            = (state != IDLE);
  assign bus.err             = err;
endmodule

// File: tb/tb_vending_session_arbiter.sv
// Randomized bench for vending_session_arbiter against a
// session-level reference model.
module tb_vending_session_arbiter;
  localparam int N  = 4;
  localparam int TO = 15;
  localparam int CL = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  vending_session_arbiter_if #(.N_SLOTS(N)) bus ();

  vending_session_arbiter #(
    .N_SLOTS(N),
    .TIMEOUT(TO),
    .CLR_LEN(CL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: a session is open or not, plus pending
  // vend/abort wind-down and a count of quiet cycles
  int m_in, m_vend, m_abort_left, m_quiet, m_owner, m_last;
  logic [1:0]   e_vm_coin;
  logic         e_clear, e_err;
  logic [N-1:0] e_sv, e_ready;

  int pend [N];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_in = 0; m_vend = 0; m_abort_left = 0; m_quiet = 0;
    m_owner = 0; m_last = N - 1;
    e_vm_coin = 0; e_clear = 0; e_err = 0; e_sv = 0; e_ready = 0;
  endtask

  task automatic take(input int s, input logic [1:0] c);
    e_ready[s] = 1'b1;
    m_owner = s;
    m_in = 1;
    m_quiet = 0;
    if (c == 2'd3) e_err = 1'b1;
    else e_vm_coin = c;
  endtask

  task automatic model_step(input logic [2*N-1:0] cs, input logic vmv);
    int s;
    bit found;
    e_ready = 0; e_vm_coin = 0; e_err = 0; e_sv = 0;
    if (m_vend != 0) begin
      m_vend = 0; m_in = 0; m_last = m_owner;
    end else if (m_abort_left > 0) begin
      m_abort_left--;
      if (m_abort_left == 0) begin
        m_in = 0; m_last = m_owner;
      end
    end else if (m_in == 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        s = (m_last + k) % N;
        if (!found && cs[2*s +: 2] != 2'd0) begin
          found = 1;
          take(s, cs[2*s +: 2]);
        end
      end
    end else begin
      if (vmv) begin
        m_vend = 1;
        e_sv[m_owner] = 1'b1;
      end else if (cs[2*m_owner +: 2] != 2'd0) begin
        take(m_owner, cs[2*m_owner +: 2]);
      end else begin
        m_quiet++;
        if (m_quiet == TO) m_abort_left = CL;
      end
    end
    e_clear = (m_abort_left > 0);
  endtask

  task automatic check_regs();
    check("vm_coin", 32'(bus.vm_coin), 32'(e_vm_coin));
    check("vm_clear", 32'(bus.vm_clear), 32'(e_clear));
    check("slot_valid", 32'(bus.slot_valid), 32'(e_sv));
    check("err", 32'(bus.err), 32'(e_err));
    check("owner", 32'(bus.owner), 32'(m_owner));
    check("busy", 32'(bus.busy), 32'(m_in != 0));
  endtask

  logic [2*N-1:0] cv;
  logic vmv;
  int coin_rate, vm_rate, r;

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) pend[i] = 0;
    bus.slot_coin = '0;
    bus.vm_valid  = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_regs();
    reset = 1'b1;

    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(negedge clk);
      check_regs();
      if (cyc % 97 == 50 && m_in != 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(negedge clk);
        check_regs();
        reset = 1'b1;
      end
      coin_rate = (cyc < 300 || cyc >= 900) ? 3 : 30;
      vm_rate   = (cyc < 300 || cyc >= 900) ? 10 : 40;
      for (int i = 0; i < N; i++) begin
        if (pend[i] == 0 && $urandom_range(0, coin_rate - 1) == 0) begin
          r = $urandom_range(0, 9);
          pend[i] = (r == 0) ? 3 : (r < 6) ? 1 : 2;
        end
        cv[2*i +: 2] = 2'(pend[i]);
      end
      vmv = ($urandom_range(0, vm_rate - 1) == 0);
      bus.slot_coin = cv;
      bus.vm_valid  = vmv;
      #1;
      model_step(cv, vmv);
      check("ready", 32'(bus.slot_coin_ready), 32'(e_ready));
      for (int i = 0; i < N; i++)
        if (e_ready[i]) pend[i] = 0;
    end

    @(negedge clk);
    check_regs();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
